lcd_bus_tx: RTL

Synthesizable 8080-style parallel LCD bus initiator for the Brain LCD interface: it drives the same wr / rs / cs_n / rst_n / data[15:0] bus that the LCD capture path in `top` receives. Upstream logic hands it command or pixel words over a valid/ready handshake. It sequences a panel hardware reset and then emits one write strobe per word with parameterised setup, strobe-low and strobe-high times. It is used as the bus source in loopback builds and as the synthesizable replacement for the behavioural LCD model in system benches.

---
 rtl/lcd_bus_tx.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_tx.sv
// lcd_bus_tx: 8080-style parallel LCD bus initiator.
// Runs a panel hardware reset sequence, then emits one wr strobe per word
// taken over a valid/ready handshake, with parameterised setup, strobe-low
// and strobe-high times. All bus pins are driven straight from registers.
// Optional feature macro: LCD_TX_BURST_EN -- keeps cs_n low across a burst
// of words terminated by i_last; when undefined i_last is ignored.
module lcd_bus_tx #(
    parameter int T_SU         = 2,
    parameter int T_WRL        = 4,
    parameter int T_WRH        = 4,
    parameter int RST_LO_CYC   = 1250,
    parameter int RST_WAIT_CYC = 12500
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_rs,
    input  logic [15:0] i_data,
    input  logic        i_last,
    input  logic        i_lcd_reset_req,
    output logic        o_busy,
    output logic        o_lcd_wr,
    output logic        o_lcd_rs,
    output logic        o_lcd_cs_n,
    output logic        o_lcd_rst_n,
    output logic [15:0] o_lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared down-counter wide enough for the longest interval.
    localparam int MAX_P = max2(max2(max2(T_SU, T_WRL), max2(T_WRH, RST_LO_CYC)), RST_WAIT_CYC);
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LD_SU    = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LD_WRL   = CNT_W'(T_WRL - 1);
    localparam logic [CNT_W-1:0] LD_WRH   = CNT_W'(T_WRH - 1);
    localparam logic [CNT_W-1:0] LD_RLO   = CNT_W'(RST_LO_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RWAIT = CNT_W'(RST_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_RST_LO   = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_WR_LO    = 3'd4,
        ST_WR_HI    = 3'd5
`ifdef LCD_TX_BURST_EN
        , ST_HOLD   = 3'd6
`endif
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             rst_req_r;
    logic             ready_r;
    logic             busy_r;
    logic             wr_r;
    logic             rs_r;
    logic             cs_n_r;
    logic             lcd_rst_n_r;
    logic [15:0]      data_r;
    logic             accept_s;
    logic             burst_ok_s;

    // A reset request in the same cycle wins over a word offer.
    assign accept_s = i_valid & ready_r & ~i_lcd_reset_req;

`ifdef LCD_TX_BURST_EN
    logic last_r;
    // Burst continues only when the word was not last and no reset is pending.
    assign burst_ok_s = ~last_r & ~rst_req_r & ~i_lcd_reset_req;
`else
    logic unused_last_s;
    assign burst_ok_s    = 1'b0;
    assign unused_last_s = i_last;
`endif

    // Bus sequencer: reset sequence, per-word strobe timing and registered bus pins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_RST_LO;
            cnt_r       <= LD_RLO;
            rst_req_r   <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
            wr_r        <= 1'b1;
            rs_r        <= 1'b0;
            cs_n_r      <= 1'b1;
            lcd_rst_n_r <= 1'b0;
            data_r      <= 16'h0000;
`ifdef LCD_TX_BURST_EN
            last_r      <= 1'b1;
`endif
        end else begin
            // Word fields land on the bus only on an accepted handshake.
            if (accept_s) begin
                rs_r   <= i_rs;
                data_r <= i_data;
            end
`ifdef LCD_TX_BURST_EN
            if (accept_s) begin
                last_r <= i_last;
            end
`endif
            // Sticky request; every branch entering RST_LO clears it again.
            if (i_lcd_reset_req) begin
                rst_req_r <= 1'b1;
            end

            case (state_r)
                ST_RST_LO: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r     <= ST_RST_WAIT;
                        cnt_r       <= LD_RWAIT;
                        lcd_rst_n_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_RST_WAIT: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (rst_req_r || i_lcd_reset_req) begin
                        state_r     <= ST_RST_LO;
                        cnt_r       <= LD_RLO;
                        lcd_rst_n_r <= 1'b0;
                        rst_req_r   <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end

                ST_IDLE: begin
                    if (i_lcd_reset_req) begin
                        state_r     <= ST_RST_LO;
                        cnt_r       <= LD_RLO;
                        lcd_rst_n_r <= 1'b0;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        rst_req_r   <= 1'b0;
                    end else if (accept_s) begin
                        state_r <= ST_SETUP;
                        cnt_r   <= LD_SU;
                        cs_n_r  <= 1'b0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_WR_LO;
                        cnt_r   <= LD_WRL;
                        wr_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_WR_LO: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_WR_HI;
                        cnt_r   <= LD_WRH;
                        wr_r    <= 1'b1;
                        // With a one-cycle high phase the next burst word is offered at once.
                        ready_r <= (T_WRH == 1) ? burst_ok_s : 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_WR_HI: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                        // Open ready in the final high cycle so a burst keeps its cadence.
                        if (cnt_r == CNT_ONE) begin
                            ready_r <= burst_ok_s;
                        end else begin
                            ready_r <= 1'b0;
                        end
                    end else if (rst_req_r || i_lcd_reset_req) begin
                        state_r     <= ST_RST_LO;
                        cnt_r       <= LD_RLO;
                        lcd_rst_n_r <= 1'b0;
                        cs_n_r      <= 1'b1;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        rst_req_r   <= 1'b0;
`ifdef LCD_TX_BURST_EN
                    end else if (!last_r) begin
                        if (accept_s) begin
                            state_r <= ST_SETUP;
                            cnt_r   <= LD_SU;
                            ready_r <= 1'b0;
                        end else begin
                            state_r <= ST_HOLD;
                            ready_r <= 1'b1;
                        end
`endif
                    end else begin
                        state_r <= ST_IDLE;
                        cs_n_r  <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end

`ifdef LCD_TX_BURST_EN
                ST_HOLD: begin
                    if (i_lcd_reset_req) begin
                        state_r     <= ST_RST_LO;
                        cnt_r       <= LD_RLO;
                        lcd_rst_n_r <= 1'b0;
                        cs_n_r      <= 1'b1;
                        ready_r     <= 1'b0;
                        rst_req_r   <= 1'b0;
                    end else if (accept_s) begin
                        state_r <= ST_SETUP;
                        cnt_r   <= LD_SU;
                        ready_r <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_r     <= ST_RST_LO;
                    cnt_r       <= LD_RLO;
                    lcd_rst_n_r <= 1'b0;
                    cs_n_r      <= 1'b1;
                    wr_r        <= 1'b1;
                    ready_r     <= 1'b0;
                    busy_r      <= 1'b1;
                    rst_req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready     = ready_r;
    assign o_busy      = busy_r;
    assign o_lcd_wr    = wr_r;
    assign o_lcd_rs    = rs_r;
    assign o_lcd_cs_n  = cs_n_r;
    assign o_lcd_rst_n = lcd_rst_n_r;
    assign o_lcd_data  = data_r;

endmodule
